// File: rtl/fc_input_sequencer.sv
// fc_input_sequencer: buffers one activation vector and streams it into a
// fully-connected PE layer with aligned weight-ROM addresses, then signals
// completion once the PE pipeline has drained.
// Optional build macro: ZERO_SKIP_EN (zero elements keep their slot but issue no valid).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; buffer writable
// S_STREAM | issuing addra = BASE_ADDR+idx, one element per cycle
// S_FLUSH  | down-counting ROM_LAT+PE_LAT cycles for valid tail + PE latency
// S_DONE   | one-cycle done pulse, busy low, buffer writable
module fc_input_sequencer #(
    parameter int WIDTH       = 24,
    parameter int FRAC        = 17,
    parameter int INPUT_NODES = 20,
    parameter int ROM_LAT     = 1,
    parameter int PE_LAT      = 2,
    parameter int BASE_ADDR   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_we,
    input  logic [9:0]       in_waddr,
    input  logic [WIDTH-1:0] in_wdata,
    input  logic             start,
    output logic             busy,
    output logic             acc_clr,
    output logic [9:0]       addra,
    output logic             valid,
    output logic [WIDTH-1:0] input_fc,
    output logic             done
);

    localparam int IDX_W = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;
    localparam int FL_W  = $clog2(ROM_LAT + PE_LAT + 1);
    localparam logic [9:0]       BASE       = 10'(BASE_ADDR);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(INPUT_NODES - 1);
    localparam logic [FL_W-1:0]  FLUSH_LOAD = FL_W'(ROM_LAT + PE_LAT - 1);

    // Reject parameter sets the address space or pipeline cannot support.
    if (INPUT_NODES < 1 || INPUT_NODES > 1024 - BASE_ADDR || ROM_LAT < 1 ||
        PE_LAT < 0 || FRAC >= WIDTH) begin : g_bad_params
        $error("fc_input_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       addra_q, addra_d;
    logic [FL_W-1:0]  flush_q, flush_d;

    logic [WIDTH-1:0] buf_q [INPUT_NODES];
    logic             buf_we;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] rd_data;
    logic             issue_vld;

    logic [WIDTH-1:0]   pipe_data_q [ROM_LAT];
    logic [WIDTH-1:0]   pipe_data_d [ROM_LAT];
    logic [ROM_LAT-1:0] pipe_vld_q, pipe_vld_d;

    assign busy     = (state_q == S_STREAM) || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);
    assign acc_clr  = (state_q == S_STREAM) && (idx_q == '0);
    assign addra    = addra_q;
    assign valid    = pipe_vld_q[ROM_LAT-1];
    assign input_fc = pipe_data_q[ROM_LAT-1];

    // Buffer write qualification and element read for the current slot.
    always_comb begin
        buf_we  = in_we && !busy && (int'(in_waddr) < INPUT_NODES);
        wr_idx  = in_waddr[IDX_W-1:0];
        rd_data = buf_q[idx_q];
`ifdef ZERO_SKIP_EN
        issue_vld = (state_q == S_STREAM) && (rd_data != '0);
`else
        issue_vld = (state_q == S_STREAM);
`endif
    end

    // Activation buffer; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wr_idx] <= in_wdata;
        end
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addra_d = addra_q;
        flush_d = flush_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                    addra_d = BASE;
                end
            end
            S_STREAM: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FLUSH;
                    flush_d = FLUSH_LOAD;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    addra_d = BASE + 10'(idx_q) + 10'd1;
                end
            end
            S_FLUSH: begin
                if (flush_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    flush_d = flush_q - FL_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; addra holds its last value between passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addra_q <= BASE;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addra_q <= addra_d;
            flush_q <= flush_d;
        end
    end

    // Data/valid delay line matching the weight-ROM read latency; idle slots carry zero.
    always_comb begin
        pipe_vld_d = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            pipe_data_d[i] = '0;
        end
        pipe_vld_d[0]  = issue_vld;
        pipe_data_d[0] = issue_vld ? rd_data : '0;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // Delay-line registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fc_input_sequencer.sv
// Testbench for fc_input_sequencer (default parameters). Honours ZERO_SKIP_EN
// when the same macro is defined for the bench build.
module tb_fc_input_sequencer;

    localparam int N    = 20;
    localparam int L    = 1;
    localparam int P    = 2;
    localparam int W    = 24;
    localparam int BASE = 0;
    localparam int NONE = 1000;
`ifdef ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_we;
    logic [9:0]   in_waddr;
    logic [W-1:0] in_wdata;
    logic         start;
    logic         busy;
    logic         acc_clr;
    logic [9:0]   addra;
    logic         valid;
    logic [W-1:0] input_fc;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] model [N];

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    fc_input_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .in_we    (in_we),
        .in_waddr (in_waddr),
        .in_wdata (in_wdata),
        .start    (start),
        .busy     (busy),
        .acc_clr  (acc_clr),
        .addra    (addra),
        .valid    (valid),
        .input_fc (input_fc),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; holds the write for one clock edge.
    task automatic wr(input int a, input logic [W-1:0] d);
        in_we    = 1'b1;
        in_waddr = 10'(a);
        in_wdata = d;
        @(negedge clk);
        in_we = 1'b0;
        if (a < N) model[a] = d;
    endtask

    // Caller has raised start at the current negedge. Checks every cycle of the
    // pass; optionally pokes start+write(buf[0]=7) in cycle poke_at, or asserts
    // reset during cycle rst_at and verifies the abort.
    task automatic run_pass(input int rst_at, input int poke_at);
        exp_t e;
        bit   ev;
        sb.delete();
        for (int k = 0; k < N; k++) begin
            if (!(ZS && model[k] == '0)) begin
                e.cyc  = k + L;
                e.data = model[k];
                sb.push_back(e);
            end
        end
        for (int c = 0; c <= N + L + P + 1; c++) begin
            @(negedge clk);
            if (c == 0 || c == poke_at + 1) begin
                start = 1'b0;
                in_we = 1'b0;
            end
            if (c == rst_at + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_valid", valid, 0);
                chk("abort_fc", input_fc, 0);
                chk("abort_done", done, 0);
                chk("abort_addra", addra, BASE);
                reset = 1'b0;
                repeat (N + L + P + 2) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                    chk("abort_idle", busy, 0);
                end
                sb.delete();
                return;
            end
            chk("addra", addra, (c < N) ? BASE + c : BASE + N - 1);
            chk("acc_clr", acc_clr, 32'(c == 0));
            chk("busy", busy, 32'(c < N + L + P));
            chk("done", done, 32'(c == N + L + P));
            ev = (sb.size() > 0) && (sb[0].cyc == c);
            chk("valid", valid, 32'(ev));
            if (ev) begin
                e = sb.pop_front();
                chk("input_fc", input_fc, e.data);
            end else begin
                chk("input_fc_idle", input_fc, 0);
            end
            if (c == poke_at) begin
                start    = 1'b1;
                in_we    = 1'b1;
                in_waddr = 10'd0;
                in_wdata = 24'd7;
            end
            if (c == rst_at) reset = 1'b1;
        end
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        // Reset held 3 cycles with start asserted.
        reset    = 1'b1;
        start    = 1'b1;
        in_we    = 1'b0;
        in_waddr = '0;
        in_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_addra", addra, BASE);
        chk("rst_valid", valid, 0);
        chk("rst_input_fc", input_fc, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", busy, 0);
        end

        // Basic pass: buf[k] = (k+1) in Q7.17.
        for (int k = 0; k < N; k++) wr(k, W'((k + 1) << 17));
        start = 1'b1;
        run_pass(NONE, NONE);

        // Out-of-range writes dropped; negative value written on the start edge.
        wr(25, 24'h123456);
        wr(36, 24'hABCDEF);
        start    = 1'b1;
        in_we    = 1'b1;
        in_waddr = 10'd5;
        in_wdata = 24'hFD0000;
        model[5] = 24'hFD0000;
        run_pass(NONE, NONE);

        // Start and write while busy are ignored; buf[0] unchanged afterwards.
        start = 1'b1;
        run_pass(NONE, 10);
        start = 1'b1;
        run_pass(NONE, NONE);

        // Reset mid-pass, then a complete fresh pass.
        start = 1'b1;
        run_pass(8, NONE);
        start = 1'b1;
        run_pass(NONE, NONE);

        // Zero elements: skipped slots with ZERO_SKIP_EN, issued otherwise.
        wr(3, 24'h0);
        wr(4, 24'h0);
        start = 1'b1;
        run_pass(NONE, NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
